// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg
//   Shared constants for the MAC array south-edge output collector.
//   COL_DEFAULT / PSUM_BW_DEFAULT match the mac_row / mac_array geometry,
//   DEPTH_DEFAULT is the per-column lane depth, and clog2_f sizes pointers.
package psum_ofifo_pkg;

  localparam int COL_DEFAULT     = 32'd8;
  localparam int PSUM_BW_DEFAULT = 32'd16;
  localparam int DEPTH_DEFAULT   = 32'd64;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
  function automatic int clog2_f(input int value);
    int result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_lane_fifo.sv
// psum_lane_fifo
//   One column lane of the output collector: a first-word-fall-through FIFO.
//   Ports:
//     clk, reset     - clock, asynchronous active-high reset
//     wr_data        - partial sum for this column
//     push           - write strobe for this column
//     pop            - shared row pop (only asserted while every lane is non-empty)
//     head           - entry at the read pointer (valid only while !empty)
//     full, empty    - occupancy flags, combinational from the count
//     overflow_pulse - one-cycle pulse when a push is dropped on a full lane
module psum_lane_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] wr_data,
  input  logic               push,
  input  logic               pop,
  output logic [psum_bw-1:0] head,
  output logic               full,
  output logic               empty,
  output logic               overflow_pulse
);

  localparam int PTR_W = clog2_f(depth);
  localparam int CNT_W = PTR_W + 32'd1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

  logic [psum_bw-1:0] mem_r [depth];
  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               full_s;
  logic               empty_s;
  logic               pop_s;
  logic               accept_s;

  // Occupancy flags and write acceptance; a full lane still takes a write
  // when the same edge pops, because the slot being freed is reused.
  always_comb begin
    full_s   = (count_r == DEPTH_CNT);
    empty_s  = (count_r == {CNT_W{1'b0}});
    pop_s    = pop & ~empty_s;
    accept_s = push & (~full_s | pop_s);
  end

  // Next count: simultaneous write and pop leaves the count unchanged.
  always_comb begin
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and count state; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // Head and status outputs.
  always_comb begin
    head           = mem_r[rptr_r];
    full           = full_s;
    empty          = empty_s;
    overflow_pulse = push & full_s & ~pop_s;
  end

endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo
//   South-edge collector for the MAC array. Each column has its own lane so
//   the one-cycle-per-column skew of the last row is absorbed; a row is
//   presented only once every lane holds data, and popped across all lanes.
//   Ports:
//     clk, reset - clock, asynchronous active-high reset
//     in         - partial sums, column c on bits [psum_bw*(c+1)-1 : psum_bw*c]
//     wr         - per-column write strobes
//     rd         - pop request; ignored while o_valid is low
//     out        - head row (zero while o_valid is low)
//     o_valid    - every lane non-empty
//     o_full     - at least one lane full
//     o_ready    - no lane full
//     overflow   - sticky per-lane dropped-write flag, cleared only by reset
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL_DEFAULT,
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [col-1:0]         overflow
);

  logic [psum_bw*col-1:0] head_s;
  logic [col-1:0]         full_s;
  logic [col-1:0]         empty_s;
  logic [col-1:0]         ovf_pulse_s;
  logic [col-1:0]         overflow_r;
  logic                   valid_s;
  logic                   pop_s;

  genvar c;
  generate
    for (c = 0; c < col; c++) begin : g_lane
      psum_lane_fifo #(
        .psum_bw (psum_bw),
        .depth   (depth)
      ) u_lane (
        .clk            (clk),
        .reset          (reset),
        .wr_data        (in[psum_bw*c +: psum_bw]),
        .push           (wr[c]),
        .pop            (pop_s),
        .head           (head_s[psum_bw*c +: psum_bw]),
        .full           (full_s[c]),
        .empty          (empty_s[c]),
        .overflow_pulse (ovf_pulse_s[c])
      );
    end
  endgenerate

  // Cross-lane row status and the shared pop.
  always_comb begin
    valid_s = &(~empty_s);
    pop_s   = rd & valid_s;
  end

  // Sticky overflow flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= {col{1'b0}};
    end else begin
      overflow_r <= overflow_r | ovf_pulse_s;
    end
  end

  // Output drive; out is zeroed so a partial row is never visible.
  always_comb begin
    o_valid  = valid_s;
    o_full   = |full_s;
    o_ready  = ~(|full_s);
    overflow = overflow_r;
    if (valid_s) begin
      out = head_s;
    end else begin
      out = {(psum_bw*col){1'b0}};
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic               clk;
  logic               reset;
  logic [BW*COL-1:0]  in_d;
  logic [COL-1:0]     wr;
  logic               rd;
  logic [BW*COL-1:0]  out_d;
  logic               o_valid;
  logic               o_full;
  logic               o_ready;
  logic [COL-1:0]     overflow;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one queue per lane plus expected sticky overflow.
  logic [BW-1:0] lq [COL][$];
  logic [COL-1:0] exp_ovf;

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_d),
    .wr       (wr),
    .rd       (rd),
    .out      (out_d),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_valid();
    for (int c = 0; c < COL; c++) begin
      if (lq[c].size() == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < COL; c++) begin
      if (lq[c].size() == DEP) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [BW*COL-1:0] model_out();
    logic [BW*COL-1:0] r;
    r = '0;
    if (!model_valid()) return r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = lq[c][0];
    return r;
  endfunction

  function automatic logic [BW*COL-1:0] fill_row(input logic [BW-1:0] base, input logic add_col);
    logic [BW*COL-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = add_col ? base + BW'(c) : base;
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < COL; c++) lq[c].delete();
    exp_ovf = '0;
  endtask

  // One clock: drive inputs, advance the model with pre-edge state, settle.
  task automatic cycle(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
    logic pop;
    pop  = r && model_valid();
    wr   = w;
    in_d = d;
    rd   = r;
    @(posedge clk);
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (lq[c].size() < DEP || pop) lq[c].push_back(d[c*BW +: BW]);
        else exp_ovf[c] = 1'b1;
      end
    end
    if (pop) begin
      for (int c = 0; c < COL; c++) void'(lq[c].pop_front());
    end
    #1;
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) cycle('0, '0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", o_full); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (out_d !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", out_d); end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL reset_ovf got=%h exp=0", overflow); end
  endtask

  task automatic test_skew();
    logic [BW*COL-1:0] row;
    logic [BW*COL-1:0] exp_row;
    do_reset();
    row = fill_row(16'h0100, 1'b1);
    exp_row = {16'h0107, 16'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int c = 0; c < COL; c++) begin
      cycle(COL'(1) << c, row, 1'b0);
      checks++;
      if (o_valid !== (c == COL - 1)) begin
        errors++; $display("FAIL skew_valid col=%0d got=%b exp=%b", c, o_valid, (c == COL - 1));
      end
    end
    checks++; if (out_d !== exp_row) begin errors++; $display("FAIL skew_out got=%h exp=%h", out_d, exp_row); end
    checks++; if (out_d !== model_out()) begin errors++; $display("FAIL skew_out_sb got=%h exp=%h", out_d, model_out()); end
    cycle('0, '0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_pop_valid got=%b exp=0", o_valid); end
    checks++; if (out_d !== '0) begin errors++; $display("FAIL skew_pop_out got=%h exp=0", out_d); end
  endtask

  task automatic test_fill_lane();
    do_reset();
    for (int i = 0; i < DEP; i++) begin
      cycle(8'h08, fill_row(BW'(i), 1'b0), 1'b0);
      checks++;
      if (o_full !== model_full() || o_full !== (i == DEP - 1)) begin
        errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, o_full, (i == DEP - 1));
      end
    end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", o_ready); end
    checks++; if (overflow !== 8'h00) begin errors++; $display("FAIL fill_ovf_pre got=%h exp=00", overflow); end
    cycle(8'h08, fill_row(16'hDEAD, 1'b0), 1'b0);
    checks++; if (overflow !== 8'h08 || overflow !== exp_ovf) begin errors++; $display("FAIL fill_ovf got=%h exp=08", overflow); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fill_valid got=%b exp=0", o_valid); end
    cycle('0, '0, 1'b0);
    checks++; if (overflow !== 8'h08) begin errors++; $display("FAIL fill_ovf_sticky got=%h exp=08", overflow); end
  endtask

  task automatic test_full_pop();
    logic [BW*COL-1:0] exp_row;
    do_reset();
    for (int r = 0; r < DEP; r++) cycle(8'hFF, fill_row(BW'(r), 1'b0), 1'b0);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fp_full got=%b exp=1", o_full); end
    for (int r = DEP; r < DEP + 200; r++) begin
      exp_row = model_out();
      checks++;
      if (out_d !== exp_row || out_d !== fill_row(BW'(r - DEP), 1'b0)) begin
        errors++; $display("FAIL fp_order row=%0d got=%h exp=%h", r - DEP, out_d, exp_row);
      end
      cycle(8'hFF, fill_row(BW'(r), 1'b0), 1'b1);
      checks++;
      if (o_full !== 1'b1 || overflow !== 8'h00) begin
        errors++; $display("FAIL fp_status row=%0d full=%b ovf=%h exp full=1 ovf=00", r, o_full, overflow);
      end
    end
    for (int r = 0; r < DEP; r++) begin
      exp_row = model_out();
      checks++;
      if (out_d !== exp_row || out_d !== fill_row(BW'(200 + r), 1'b0)) begin
        errors++; $display("FAIL fp_drain row=%0d got=%h exp=%h", r, out_d, exp_row);
      end
      cycle('0, '0, 1'b1);
    end
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL fp_empty valid=%b ready=%b exp 0/1", o_valid, o_ready); end
  endtask

  task automatic test_rd_empty();
    logic [BW*COL-1:0] row_a;
    logic [BW*COL-1:0] row_b;
    do_reset();
    row_a = fill_row(16'h0A00, 1'b1);
    row_b = fill_row(16'h0B00, 1'b1);
    cycle(8'hDF, row_a, 1'b0);
    cycle(8'hDF, row_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, '0, 1'b1);
      checks++;
      if (o_valid !== 1'b0 || out_d !== '0) begin
        errors++; $display("FAIL rde_idle i=%0d valid=%b out=%h exp 0/0", i, o_valid, out_d);
      end
    end
    cycle(8'h20, row_a, 1'b0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rde_valid got=%b exp=1", o_valid); end
    checks++; if (out_d !== row_a) begin errors++; $display("FAIL rde_oldest got=%h exp=%h", out_d, row_a); end
    cycle(8'h20, row_b, 1'b0);
    cycle('0, '0, 1'b1);
    checks++; if (out_d !== row_b || out_d !== model_out()) begin errors++; $display("FAIL rde_second got=%h exp=%h", out_d, row_b); end
    cycle('0, '0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rde_drained got=%b exp=0", o_valid); end
  endtask

  task automatic test_async_reset();
    logic [BW*COL-1:0] row_x;
    do_reset();
    for (int r = 0; r < 3; r++) cycle(8'hFF, fill_row(BW'(16'h0300 + r), 1'b1), 1'b0);
    for (int i = 0; i < DEP; i++) cycle(8'h01, fill_row(16'h0001, 1'b0), 1'b0);
    checks++; if (o_valid !== 1'b1 || overflow !== 8'h01) begin errors++; $display("FAIL ar_pre valid=%b ovf=%h exp 1/01", o_valid, overflow); end
    #2;
    reset = 1'b1;
    #1;
    clear_model();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", o_valid); end
    checks++; if (out_d !== '0) begin errors++; $display("FAIL ar_out got=%h exp=0", out_d); end
    checks++; if (o_full !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL ar_full full=%b ready=%b exp 0/1", o_full, o_ready); end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL ar_ovf got=%h exp=0", overflow); end
    #2;
    reset = 1'b0;
    row_x = fill_row(16'hABCD, 1'b0);
    cycle(8'hFF, row_x, 1'b0);
    checks++; if (o_valid !== 1'b1 || out_d !== row_x) begin errors++; $display("FAIL ar_post valid=%b out=%h exp 1/%h", o_valid, out_d, row_x); end
    cycle('0, '0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ar_post_pop got=%b exp=0", o_valid); end
  endtask

  initial begin
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    in_d  = '0;
    clear_model();
    test_reset();
    test_skew();
    test_fill_lane();
    test_full_pop();
    test_rd_empty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
